// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, MMIO map and helpers for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [4:0] OFF_CONSOLE  = 5'h00;
  localparam logic [4:0] OFF_MTIME_LO = 5'h04;
  localparam logic [4:0] OFF_MTIME_HI = 5'h08;
  localparam logic [4:0] OFF_TOHOST   = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  // Illegal size encodings are folded into the alignment check.
  function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] lo);
    logic bad;
    case (size_e'(sel))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/console_txbuf.sv
// rtl/console_txbuf.sv - one-entry console holding buffer with valid/ready drain
module console_txbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       overflow
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic       drain;

  assign drain = valid_q && tx_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (drain) begin
      valid_d = 1'b0;
    end
    // A write in the draining cycle refills the slot, so tx_valid never drops.
    if (wr_en) begin
      if (!valid_q || drain) begin
        valid_d = 1'b1;
        data_d  = wr_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder: RAM, MMIO console/timer/tohost, error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_byte_sel,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [63:0] mtime_q, mtime_d;
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;

  size_e       size;
  logic        misaligned;
  logic        ram_hit, mmio_hit, mmio_ok;
  logic [31:0] mmio_off;
  logic [4:0]  reg_off;
  logic [AW-1:0] word_idx;
  logic [31:0] ram_word, ram_shifted;
  logic [31:0] rdata_c;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        mmio_wr, cons_wr, store_err;
  logic        overflow;

  assign size       = size_e'(mem_byte_sel);
  assign misaligned = is_misaligned(mem_byte_sel, mem_addr[1:0]);
  assign ram_hit    = (mem_addr >> (AW + 2)) == 32'd0;
  // Unsigned subtract makes addresses below the base wrap far out of the window.
  assign mmio_off   = mem_addr - MMIO_BASE;
  assign mmio_hit   = (mmio_off[31:5] == 27'd0);
  assign reg_off    = mmio_off[4:0];
  assign mmio_ok    = mmio_hit && !misaligned && (size == SZ_WORD);

  assign word_idx    = mem_addr[AW+1:2];
  assign ram_word    = ram_q[word_idx];
  assign ram_shifted = ram_word >> {mem_addr[1:0], 3'b000};

  always_comb begin
    rdata_c = 32'h0;
    if (!misaligned) begin
      if (ram_hit) begin
        case (size)
          SZ_BYTE: rdata_c = {24'h0, ram_shifted[7:0]};
          SZ_HALF: rdata_c = {16'h0, ram_shifted[15:0]};
          SZ_WORD: rdata_c = ram_shifted;
          default: rdata_c = 32'h0;
        endcase
      end else if (mmio_ok) begin
        case (reg_off)
          OFF_MTIME_LO: rdata_c = mtime_q[31:0];
          OFF_MTIME_HI: rdata_c = mtime_q[63:32];
          OFF_TOHOST:   rdata_c = tohost_q;
          OFF_STATUS:   rdata_c = {29'h0, overflow, err_q, tx_valid};
          default:      rdata_c = 32'h0;
        endcase
      end
    end
  end

  assign mem_rdata = rdata_c;

  always_comb begin
    ram_we    = mem_we && ram_hit && !misaligned && !rst;
    ram_wdata = mem_wdata << {mem_addr[1:0], 3'b000};
    case (size)
      SZ_BYTE: ram_be = 4'b0001 << mem_addr[1:0];
      SZ_HALF: ram_be = 4'b0011 << {mem_addr[1], 1'b0};
      SZ_WORD: ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          ram_q[word_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mmio_wr   = mem_we && mmio_ok;
  assign cons_wr   = mmio_wr && (reg_off == OFF_CONSOLE);
  assign store_err = mem_we && (misaligned || (!ram_hit && !mmio_hit) ||
                                (mmio_hit && (size != SZ_WORD)));

  always_comb begin
    mtime_d  = mtime_q + 64'd1;
    tohost_d = tohost_q;
    halt_d   = halt_q;
    err_d    = err_q | store_err;
    if (mmio_wr && (reg_off == OFF_TOHOST) && (mem_wdata != 32'h0)) begin
      tohost_d = mem_wdata;
      halt_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= 64'h0;
      tohost_q <= 32'h0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

  console_txbuf u_txbuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cons_wr),
    .wr_data  (mem_wdata[7:0]),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .overflow (overflow)
  );

  assign halt = halt_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [1:0]  mem_byte_sel;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_byte_sel (mem_byte_sel),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .halt         (halt),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic we, input logic [31:0] a,
                              input logic [1:0] s, input logic [31:0] wd,
                              input logic c, input logic [31:0] rd, input logic e);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.sel = s; v.wdata = wd;
    v.chk_rd = c; v.rd = rd; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] s);
    mem_we = 1'b0; mem_addr = a; mem_byte_sel = s;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_byte_sel = s; mem_wdata = d;
    step();
    mem_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_we = 1'b0; mem_addr = 32'h0; mem_byte_sel = 2'b10;
    mem_wdata = 32'h0; tx_ready = 1'b0;

    vecs.push_back(mk("st_w_10",    1, 32'h10,  2'b10, 32'hDEADBEEF, 0, 32'h0,        0));
    vecs.push_back(mk("ld_b_13",    0, 32'h13,  2'b00, 32'h0,        1, 32'h000000DE, 0));
    vecs.push_back(mk("ld_b_10",    0, 32'h10,  2'b00, 32'h0,        1, 32'h000000EF, 0));
    vecs.push_back(mk("ld_h_12",    0, 32'h12,  2'b01, 32'h0,        1, 32'h0000DEAD, 0));
    vecs.push_back(mk("st_h_12",    1, 32'h12,  2'b01, 32'hABCD1234, 0, 32'h0,        0));
    vecs.push_back(mk("ld_w_10",    0, 32'h10,  2'b10, 32'h0,        1, 32'h1234BEEF, 0));
    vecs.push_back(mk("st_w_20",    1, 32'h20,  2'b10, 32'h00000000, 0, 32'h0,        0));
    vecs.push_back(mk("st_b_21",    1, 32'h21,  2'b00, 32'hFFFFFFA5, 0, 32'h0,        0));
    vecs.push_back(mk("ld_w_20",    0, 32'h20,  2'b10, 32'h0,        1, 32'h0000A500, 0));
    vecs.push_back(mk("ld_h_22",    0, 32'h22,  2'b01, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("ld_h_20",    0, 32'h20,  2'b01, 32'h0,        1, 32'h0000A500, 0));
    vecs.push_back(mk("st_w_top",   1, 32'hFFC, 2'b10, 32'hCAFEF00D, 0, 32'h0,        0));
    vecs.push_back(mk("ld_w_top",   0, 32'hFFC, 2'b10, 32'h0,        1, 32'hCAFEF00D, 0));
    vecs.push_back(mk("ld_unmap",   0, 32'h1000,2'b10, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("ld_mis_h",   0, 32'h11,  2'b01, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("ld_mis_w",   0, 32'h12,  2'b10, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("ld_sel11",   0, 32'h10,  2'b11, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("status0",    0, B+32'h10,2'b10, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("tohost0",    0, B+32'h0C,2'b10, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("mmio_sub",   0, B+32'h04,2'b00, 32'h0,        1, 32'h00000000, 0));
    vecs.push_back(mk("st_mis_h",   1, 32'h11,  2'b01, 32'h0000FFFF, 0, 32'h0,        1));
    vecs.push_back(mk("ld_w_10b",   0, 32'h10,  2'b10, 32'h0,        1, 32'h1234BEEF, 1));
    vecs.push_back(mk("status_err", 0, B+32'h10,2'b10, 32'h0,        1, 32'h00000002, 1));

    step(); step();
    rst = 1'b0;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
    chk("rst_halt",     {31'h0, halt},     32'h0);
    chk("rst_err",      {31'h0, err},      32'h0);
    rd(B + 32'h04, 2'b10);
    chk("rst_mtime_lo", mem_rdata, 32'h0);
    repeat (10) step();
    rd(B + 32'h04, 2'b10);
    chk("mtime_10", mem_rdata, 32'd10);

    foreach (vecs[i]) begin
      mem_we = vecs[i].we; mem_addr = vecs[i].addr;
      mem_byte_sel = vecs[i].sel; mem_wdata = vecs[i].wdata;
      #1;
      if (vecs[i].chk_rd) chk({vecs[i].name, "_rd"}, mem_rdata, vecs[i].rd);
      step();
      mem_we = 1'b0;
      chk({vecs[i].name, "_err"}, {31'h0, err}, {31'h0, vecs[i].err});
    end

    // MTIME carry from low to high half
    mem_addr = B + 32'h08; mem_byte_sel = 2'b10;
    force dut.mtime_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.mtime_q;
    #1;
    chk("mtime_hi_pre", mem_rdata, 32'h0);
    rd(B + 32'h04, 2'b10);
    chk("mtime_lo_pre", mem_rdata, 32'hFFFFFFFF);
    step();
    rd(B + 32'h08, 2'b10);
    chk("mtime_hi_carry", mem_rdata, 32'h1);
    wr(B + 32'h04, 2'b10, 32'hFFFF0000);
    rd(B + 32'h04, 2'b10);
    chk("mtime_wr_ignored", mem_rdata, 32'h1);

    // Console handshake
    mem_we = 1'b1; mem_addr = B; mem_byte_sel = 2'b10; mem_wdata = 32'h41;
    #1;
    chk("cons_latency", {31'h0, tx_valid}, 32'h0);
    step(); mem_we = 1'b0;
    chk("cons41_valid", {31'h0, tx_valid}, 32'h1);
    chk("cons41_data",  {24'h0, tx_data},  32'h41);
    rd(B + 32'h10, 2'b10);
    chk("cons41_status", mem_rdata, 32'h3);
    tx_ready = 1'b1;
    wr(B, 2'b10, 32'h43);
    tx_ready = 1'b0;
    chk("cons43_valid", {31'h0, tx_valid}, 32'h1);
    chk("cons43_data",  {24'h0, tx_data},  32'h43);
    rd(B + 32'h10, 2'b10);
    chk("cons43_no_ovf", mem_rdata, 32'h3);
    wr(B, 2'b10, 32'h42);
    chk("cons42_drop", {24'h0, tx_data}, 32'h43);
    rd(B + 32'h10, 2'b10);
    chk("cons42_ovf", mem_rdata, 32'h7);
    rd(B, 2'b10);
    chk("cons_rd_zero", mem_rdata, 32'h0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("cons_drained", {31'h0, tx_valid}, 32'h0);
    rd(B + 32'h10, 2'b10);
    chk("cons_status_empty", mem_rdata, 32'h6);

    // TOHOST
    mem_we = 1'b1; mem_addr = B + 32'h0C; mem_byte_sel = 2'b10; mem_wdata = 32'h1;
    #1;
    chk("halt_pre", {31'h0, halt}, 32'h0);
    step(); mem_we = 1'b0;
    chk("halt_set", {31'h0, halt}, 32'h1);
    rd(B + 32'h0C, 2'b10);
    chk("tohost_rd", mem_rdata, 32'h1);
    wr(B + 32'h0C, 2'b10, 32'h0);
    rd(B + 32'h0C, 2'b10);
    chk("tohost_wr0_ignored", mem_rdata, 32'h1);
    chk("halt_sticky", {31'h0, halt}, 32'h1);

    // Reset mid-handshake with a concurrent store
    wr(B, 2'b10, 32'h55);
    chk("cons55_valid", {31'h0, tx_valid}, 32'h1);
    rst = 1'b1; tx_ready = 1'b1;
    mem_we = 1'b1; mem_addr = 32'h10; mem_byte_sel = 2'b10; mem_wdata = 32'h99999999;
    step();
    rst = 1'b0; tx_ready = 1'b0; mem_we = 1'b0;
    chk("prst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("prst_tx_data",  {24'h0, tx_data},  32'h0);
    chk("prst_halt",     {31'h0, halt},     32'h0);
    chk("prst_err",      {31'h0, err},      32'h0);
    rd(B + 32'h0C, 2'b10);
    chk("prst_tohost", mem_rdata, 32'h0);
    rd(B + 32'h10, 2'b10);
    chk("prst_status", mem_rdata, 32'h0);
    rd(32'h10, 2'b10);
    chk("prst_ram_kept", mem_rdata, 32'h1234BEEF);
    step();
    chk("prst_no_present", {31'h0, tx_valid}, 32'h0);

    // Unmapped store must not alias into RAM
    wr(32'h0, 2'b10, 32'h11111111);
    chk("st0_err", {31'h0, err}, 32'h0);
    wr(32'h1000, 2'b10, 32'h22222222);
    chk("unmap_st_err", {31'h0, err}, 32'h1);
    rd(32'h0, 2'b10);
    chk("unmap_no_alias", mem_rdata, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1000_0000, meaning the base address of the 32-byte MMIO window.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: mem_addr  in  32  byte address; mem_byte_sel  in  2  size (00 byte, 01 half, 10 word, 11 illegal); mem_wdata  in  32  store data, right-aligned; mem_we  in  1  store strobe.
REQ-005 SHALL have ports: mem_rdata  out  32  load data, right-aligned, unextended.
REQ-006 SHALL have ports: tx_data  out  8  console byte; tx_valid  out  1  byte available; tx_ready  in  1  consumer accepts.
REQ-007 SHALL have ports: halt  out  1  TOHOST written; err  out  1  sticky access error.

Function
REQ-008 SHALL decode RAM at addresses 0 to 4*DEPTH_WORDS-1, MMIO at MMIO_BASE to MMIO_BASE+0x1F, and everything else as unmapped.
REQ-009 SHALL return mem_rdata combinationally from mem_addr in the same cycle; reads SHALL have no side effects.
REQ-010 SHALL right-shift the addressed word by 8*addr[1:0] for byte loads and 16*addr[1] for half loads, with unused upper bits zero.
REQ-011 SHALL perform RAM stores at the rising edge while mem_we=1, left-shifting mem_wdata by the same lane offset and writing only the enabled byte lanes (1, 2 or 4).
REQ-012 SHALL treat the following as misaligned, with no state change, mem_rdata=0 and err set on the next edge if mem_we=1: a half access with addr[0]=1; a word access with addr[1:0]!=0; or mem_byte_sel=11.
REQ-013 SHALL return 0 for unmapped reads; an unmapped store SHALL be dropped and SHALL set err.
REQ-014 SHALL provide MMIO register CONSOLE at offset 0x00: a write loads wdata[7:0] into a one-entry holding buffer; a read returns 0.
REQ-015 SHALL provide MMIO registers MTIME_LO and MTIME_HI at offsets 0x04 and 0x08, read-only halves of a 64-bit counter that increments every cycle and wraps to 0 after all-ones; writes SHALL be ignored.
REQ-016 SHALL provide MMIO register TOHOST at offset 0x0C: a write of a nonzero value SHALL set halt sticky and latch the value; a read returns the latched value; a write of 0 SHALL be ignored.
REQ-017 SHALL provide MMIO register STATUS at offset 0x10, read-only, as {29'b0, overflow, err, tx_valid}.
REQ-018 SHALL accept MMIO accesses only as aligned words; sub-word MMIO accesses follow REQ-012 as errors.
REQ-019 SHALL drive the console buffer as follows: tx_valid=1 while the buffer is full; tx_data is stable while tx_valid=1; the buffer empties on the edge where tx_valid and tx_ready are both 1.
REQ-020 SHALL, on a CONSOLE write while the buffer is full and not draining that cycle, drop the byte and set overflow sticky.
REQ-021 SHALL, on a CONSOLE write in the same cycle the buffer drains, load the new byte; tx_valid then stays 1 with no bubble.
REQ-022 SHALL, on a CONSOLE write while the buffer is empty, assert tx_valid on the next cycle (one-cycle latency).
REQ-023 SHALL keep halt and overflow as sticky flags, clearable only by reset; halt SHALL NOT block further accesses.

Reset
REQ-024 SHALL, on an edge with rst=1, clear tx_valid, tx_data, halt, err, overflow, TOHOST and MTIME to 0, ignoring any concurrent store.
REQ-025 SHALL leave RAM contents unchanged by reset; mem_rdata follows REQ-009 during reset.
REQ-026 SHALL discard a pending console byte on reset mid-handshake, without presenting it.

Structure
REQ-027 SHALL place the size encodings, MMIO offsets and the MMIO_BASE default in shared package dmem_pkg.
REQ-028 SHALL implement the console holding buffer and handshake as sub-module console_txbuf; RAM and decode stay in dmem_responder.

Verification
REQ-029 SHALL cover: word store 0xDEADBEEF at 0x10, byte load 0x13 -> 0x000000DE; half store 0x1234 at 0x12, word load 0x10 -> 0x1234BEEF.
REQ-030 SHALL cover: half store at 0x11 -> RAM unchanged, err=1 next cycle, STATUS read = 0x2.
REQ-031 SHALL cover: CONSOLE write 0x41 with tx_ready=0 -> tx_valid=1 and tx_data=0x41 next cycle; second write 0x42 -> dropped, overflow=1; tx_ready=1 -> 0x41 consumed, tx_valid=0.
REQ-032 SHALL cover: buffer full, CONSOLE write 0x43 with tx_ready=1 in the same cycle -> tx_valid remains 1, tx_data=0x43, overflow unchanged.
REQ-033 SHALL cover: reset released, 10 cycles later MTIME_LO read = 10; counter preloaded via force to 0xFFFFFFFF -> MTIME_HI increments by 1 on the next edge.
REQ-034 SHALL cover: TOHOST write 1 -> halt=1 and TOHOST read = 1; rst pulse -> halt=0, while RAM word at 0x10 still reads 0x1234BEEF.
